// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run controller: FSM state encoding,
// the EBREAK opcode, and counter/index width helpers.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_HOLD = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } run_state_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // Width needed to hold the values 0..n (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index into a buffer of 'depth' entries (never narrower than 1 bit).
    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// PC history ring: one entry written per enabled cycle, read back relative
// to the newest entry (rd_idx 0 = most recent). clear wipes contents and pointer.
module pc_trace_buf
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            clear,
    input  logic                            we,
    input  logic [PC_W-1:0]                 wr_pc,
    input  logic [idx_w(TRACE_DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]                 rd_pc
);

    localparam int IDX_W = idx_w(TRACE_DEPTH);

    logic [TRACE_DEPTH-1:0][PC_W-1:0] mem_q, mem_d;
    logic [IDX_W-1:0]                 wptr_q, wptr_d;
    logic [IDX_W-1:0]                 rd_ptr;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        if (clear) begin
            mem_d  = '0;
            wptr_d = '0;
        end else if (we) begin
            mem_d[wptr_q] = wr_pc;
            wptr_d        = wptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
    end

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign rd_ptr = wptr_q - IDX_W'(1) - rd_idx;
    assign rd_pc  = mem_q[rd_ptr];

endmodule

// File: rtl/run_controller.sv
// Run-control harness for the single-cycle core: reset hold, cycle count,
// halt on EBREAK / PC self-loop / max cycles. Optional PC trace via RUN_CTRL_TRACE_EN.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 20,
    parameter int HALT_STABLE  = 2,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [PC_W-1:0]                 pc,
    input  logic [31:0]                     instr,
    output logic                            core_reset,
    output logic                            running,
    output logic                            done,
    output logic                            timeout,
    output logic [PC_W-1:0]                 halt_pc,
`ifdef RUN_CTRL_TRACE_EN
    input  logic [idx_w(TRACE_DEPTH)-1:0]   trace_idx,
    output logic [PC_W-1:0]                 trace_pc,
`endif
    output logic [cnt_w(MAX_CYCLES)-1:0]    cycle_count
);

    localparam int CNT_W  = cnt_w(MAX_CYCLES);
    localparam int HOLD_W = cnt_w(RESET_CYCLES);
    localparam int STB_W  = cnt_w(HALT_STABLE);

    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
        $error("TRACE_DEPTH must be a power of two >= 2");
    end

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
    logic              core_reset_q, core_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [CNT_W-1:0]  k;
    logic [STB_W-1:0]  stable_nxt;
    logic              pc_same, is_ebreak, is_loop, is_max, start_ok;

    // k is the 1-based index of the current RUN cycle; prev_pc is only
    // meaningful once a RUN cycle has completed (cnt_q != 0).
    assign k          = (cnt_q == CNT_W'(MAX_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
    assign is_ebreak  = (instr == EBREAK_INSN);
    assign pc_same    = (cnt_q != '0) && (pc == prev_pc_q);
    assign stable_nxt = !pc_same ? '0 :
                        (stable_q == STB_W'(HALT_STABLE)) ? stable_q : stable_q + STB_W'(1);
    assign is_loop    = pc_same && (stable_nxt == STB_W'(HALT_STABLE));
    assign is_max     = (k == CNT_W'(MAX_CYCLES));
    assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        prev_pc_d    = prev_pc_q;
        halt_pc_d    = halt_pc_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RST_HOLD;
                    hold_d       = HOLD_W'(RESET_CYCLES - 1);
                    cnt_d        = '0;
                    stable_d     = '0;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    core_reset_d = 1'b1;
                    running_d    = 1'b0;
                end
            end
            S_RST_HOLD: begin
                if (hold_q == '0) begin
                    state_d      = S_RUN;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                cnt_d     = k;
                stable_d  = stable_nxt;
                prev_pc_d = pc;
                if (is_ebreak || is_loop || is_max) begin
                    state_d      = S_DONE;
                    halt_pc_d    = pc;
                    done_d       = 1'b1;
                    timeout_d    = is_max && !is_ebreak && !is_loop;
                    core_reset_d = 1'b1;
                    running_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            prev_pc_q    <= '0;
            halt_pc_q    <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            prev_pc_q    <= prev_pc_d;
            halt_pc_q    <= halt_pc_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cnt_q;

`ifdef RUN_CTRL_TRACE_EN
    logic trace_clr;
    assign trace_clr = reset || start_ok;

    pc_trace_buf #(
        .PC_W        (PC_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .clear  (trace_clr),
        .we     (state_q == S_RUN),
        .wr_pc  (pc),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc)
    );
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed testbench for run_controller (default parameters); trace checks
// are compiled in when RUN_CTRL_TRACE_EN is defined.
module tb_run_controller;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_reset, running, done, timeout;
    logic [31:0] halt_pc;
    logic [4:0]  cycle_count;
`ifdef RUN_CTRL_TRACE_EN
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    run_controller dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .instr       (instr),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .halt_pc     (halt_pc),
`ifdef RUN_CTRL_TRACE_EN
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc),
`endif
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse plus the two hold cycles; returns in RUN cycle 1.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if ({core_reset, running, done, timeout} !== 4'b1000) begin
            $display("FAIL reset_flags got %b want 1000", {core_reset, running, done, timeout});
            n_fail++;
        end
        n_tests++;
        if (halt_pc !== 32'h0 || cycle_count !== 5'd0) begin
            $display("FAIL reset_vals got halt_pc=%h cc=%0d want 0/0", halt_pc, cycle_count);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({core_reset, running, done} !== 3'b100) begin
            $display("FAIL idle_no_start got %b want 100", {core_reset, running, done});
            n_fail++;
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({core_reset, running} !== 2'b10) begin
            $display("FAIL hold_c1 got %b want 10", {core_reset, running});
            n_fail++;
        end
        tick();
        n_tests++;
        if ({core_reset, running} !== 2'b10) begin
            $display("FAIL hold_c2 got %b want 10", {core_reset, running});
            n_fail++;
        end
        tick();
        n_tests++;
        if ({core_reset, running} !== 2'b01) begin
            $display("FAIL run_c1 got %b want 01", {core_reset, running});
            n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_ebreak();
        start_run();
        for (int k = 1; k <= 5; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = (k == 5) ? EBREAK : NOP;
            if (k == 3) begin
                n_tests++;
                if (cycle_count !== 5'd2 || running !== 1'b1) begin
                    $display("FAIL ebreak_midrun got cc=%0d run=%b want 2/1", cycle_count, running);
                    n_fail++;
                end
            end
            tick();
        end
        instr = NOP;
        n_tests++;
        if ({core_reset, running, done, timeout} !== 4'b1010 || halt_pc !== 32'h10 || cycle_count !== 5'd5) begin
            $display("FAIL ebreak_halt got flags=%b pc=%h cc=%0d want 1010/10/5",
                     {core_reset, running, done, timeout}, halt_pc, cycle_count);
            n_fail++;
        end
        pc = 32'h100;
        tick();
        tick();
        n_tests++;
        if (done !== 1'b1 || halt_pc !== 32'h10 || cycle_count !== 5'd5) begin
            $display("FAIL done_hold got done=%b pc=%h cc=%0d want 1/10/5", done, halt_pc, cycle_count);
            n_fail++;
        end
    endtask

    task automatic test_self_loop();
        logic [31:0] seq [5];
        seq = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
        start_run();
        for (int k = 1; k <= 5; k++) begin
            pc    = seq[k-1];
            instr = NOP;
            tick();
            if (k == 4) begin
                n_tests++;
                if (done !== 1'b0) begin
                    $display("FAIL loop_early got done=%b want 0", done);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b0 || halt_pc !== 32'h8 || cycle_count !== 5'd5) begin
            $display("FAIL loop_halt got done=%b to=%b pc=%h cc=%0d want 1/0/8/5",
                     done, timeout, halt_pc, cycle_count);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        start_run();
        for (int k = 1; k <= 20; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = NOP;
            tick();
        end
        n_tests++;
        if ({core_reset, running, done, timeout} !== 4'b1011 || cycle_count !== 5'd20 || halt_pc !== 32'h4C) begin
            $display("FAIL timeout got flags=%b cc=%0d pc=%h want 1011/20/4c",
                     {core_reset, running, done, timeout}, cycle_count, halt_pc);
            n_fail++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({core_reset, done, timeout} !== 3'b100 || cycle_count !== 5'd0) begin
            $display("FAIL restart_clear got flags=%b cc=%0d want 100/0", {core_reset, done, timeout}, cycle_count);
            n_fail++;
        end
        tick();
        tick();
        for (int k = 1; k <= 20; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = (k == 20) ? EBREAK : NOP;
            tick();
        end
        instr = NOP;
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 5'd20) begin
            $display("FAIL ebreak_at_max got done=%b to=%b cc=%0d want 1/0/20", done, timeout, cycle_count);
            n_fail++;
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        n_tests++;
        if (running !== 1'b1 || core_reset !== 1'b0) begin
            $display("FAIL start_in_hold got run=%b cr=%b want 1/0", running, core_reset);
            n_fail++;
        end
        for (int k = 1; k <= 6; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = NOP;
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (running !== 1'b1 || done !== 1'b0 || cycle_count !== 5'd6) begin
            $display("FAIL start_in_run got run=%b done=%b cc=%0d want 1/0/6", running, done, cycle_count);
            n_fail++;
        end
        pc    = 32'h18;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({core_reset, running, done, timeout} !== 4'b1000 || halt_pc !== 32'h0 || cycle_count !== 5'd0) begin
            $display("FAIL reset_midrun got flags=%b pc=%h cc=%0d want 1000/0/0",
                     {core_reset, running, done, timeout}, halt_pc, cycle_count);
            n_fail++;
        end
    endtask

`ifdef RUN_CTRL_TRACE_EN
    task automatic test_trace();
        start_run();
        for (int k = 1; k <= 10; k++) begin
            pc    = 32'(4 * (k - 1));
            instr = (k == 10) ? EBREAK : NOP;
            tick();
        end
        instr     = NOP;
        trace_idx = 3'd0;
        #1;
        n_tests++;
        if (trace_pc !== 32'h24) begin
            $display("FAIL trace_idx0 got %h want 24", trace_pc);
            n_fail++;
        end
        trace_idx = 3'd1;
        #1;
        n_tests++;
        if (trace_pc !== 32'h20) begin
            $display("FAIL trace_idx1 got %h want 20", trace_pc);
            n_fail++;
        end
        trace_idx = 3'd7;
        #1;
        n_tests++;
        if (trace_pc !== 32'h08) begin
            $display("FAIL trace_idx7 got %h want 08", trace_pc);
            n_fail++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            n_tests++;
            if (trace_pc !== 32'h0) begin
                $display("FAIL trace_clear idx%0d got %h want 0", i, trace_pc);
                n_fail++;
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pc    = 32'h0;
        instr = NOP;
`ifdef RUN_CTRL_TRACE_EN
        trace_idx = 3'd0;
`endif
        test_reset();
        test_start();
        test_ebreak();
        test_self_loop();
        test_timeout();
        test_reset_midrun();
`ifdef RUN_CTRL_TRACE_EN
        test_trace();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
